// File: rtl/countdown_pkg.sv
// countdown_pkg: shared state encoding and display mode constants for the countdown LED sequencer
package countdown_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FLASH} state_e;
    localparam logic [1:0] MODE_BAR   = 2'd0;
    localparam logic [1:0] MODE_DOT   = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
endpackage

// File: rtl/cd_prescaler.sv
// cd_prescaler: counts enabled clocks 0..DIV-1 and pulses tick on the terminal count
module cd_prescaler #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
    logic [CW-1:0] cnt_q;
    assign tick = en && (cnt_q == CW'(DIV - 1));
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else if (clr) cnt_q <= '0;
        else if (en) cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
endmodule

// File: rtl/countdown_led_seq.sv
// countdown_led_seq: ring-triggered LED_N-step countdown on an LED bar with end flash burst and done pulse
module countdown_led_seq
    import countdown_pkg::*;
#(
    parameter int LED_N     = 16,
    parameter int TICK_DIV  = 1000,
    parameter int BLINK_DIV = 250,
    parameter int FLASH_N   = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ring,
    input  logic             cancel,
    input  logic [1:0]       mode,
    output logic [LED_N-1:0] led,
    output logic             busy,
    output logic             done
);
    localparam int SW = $clog2(LED_N + 1);
    localparam int FW = $clog2(2 * FLASH_N);
    state_e           state_q;
    logic [SW-1:0]    step_q, step_d;
    logic [FW-1:0]    flash_q;
    logic [1:0]       mode_q, mode_l;
    logic [LED_N-1:0] led_q;
    logic             ring_q, phase_q, phase_d, done_q;
    logic             rise, step_tick, blink_tick, step_clr, blink_clr, last_flash;

    function automatic logic [LED_N-1:0] pattern(input logic [1:0] m, input logic [SW-1:0] s,
                                                 input logic ph);
        logic [LED_N:0] bar;
        bar = ((LED_N + 1)'(1) << s) - (LED_N + 1)'(1);
        case (m)
            MODE_DOT:   return LED_N'(1) << (s - 1'b1);
            MODE_BLINK: return ph ? '1 : '0;
            default:    return bar[LED_N-1:0];
        endcase
    endfunction

    assign rise       = ring & ~ring_q;
    assign mode_l     = (mode == MODE_DOT || mode == MODE_BLINK) ? mode : MODE_BAR;
    assign step_d     = step_tick ? step_q - 1'b1 : step_q;
    assign phase_d    = blink_tick ? ~phase_q : phase_q;
    assign last_flash = blink_tick && (flash_q == FW'(2 * FLASH_N - 1));
    assign step_clr   = cancel | rise | (state_q != RUN);
    // Blink prescaler restarts on entry to FLASH so the burst opens with a full on half-period
    assign blink_clr  = cancel | rise | (state_q == IDLE) | (state_q == RUN && step_d == '0);

    cd_prescaler #(.DIV(TICK_DIV)) u_step (
        .clk(clk), .reset_n(reset_n), .clr(step_clr), .en(state_q == RUN), .tick(step_tick)
    );
    cd_prescaler #(.DIV(BLINK_DIV)) u_blink (
        .clk(clk), .reset_n(reset_n), .clr(blink_clr), .en(state_q != IDLE), .tick(blink_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            flash_q <= '0;
            mode_q  <= MODE_BAR;
            ring_q  <= 1'b0;
            phase_q <= 1'b0;
            done_q  <= 1'b0;
            led_q   <= '0;
        end else begin
            ring_q <= ring;
            done_q <= 1'b0;
            if (cancel) begin
                state_q <= IDLE;
                step_q  <= '0;
                led_q   <= '0;
            end else if (rise) begin
                state_q <= RUN;
                step_q  <= SW'(LED_N);
                mode_q  <= mode_l;
                phase_q <= 1'b1;
                flash_q <= '0;
                led_q   <= pattern(mode_l, SW'(LED_N), 1'b1);
            end else begin
                case (state_q)
                    RUN: begin
                        if (step_d == '0) begin
                            state_q <= FLASH;
                            step_q  <= '0;
                            flash_q <= '0;
                            phase_q <= 1'b1;
                            led_q   <= '1;
                        end else begin
                            step_q  <= step_d;
                            phase_q <= phase_d;
                            led_q   <= pattern(mode_q, step_d, phase_d);
                        end
                    end
                    FLASH: begin
                        if (last_flash) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                            led_q   <= '0;
                        end else begin
                            flash_q <= flash_q + FW'(blink_tick);
                            phase_q <= phase_d;
                            led_q   <= phase_d ? '1 : '0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        led_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign led  = led_q;
    assign busy = state_q != IDLE;
    assign done = done_q;
endmodule
